// File: rtl/up_axi_master_if.sv
// Bus bundle for up_axi_master: the simple up_* request/ack port and the AXI4-Lite master channels.
// The master modport is the bridge's view; slave is the view of the requester/AXI target side.
interface up_axi_master_if;
  logic        up_wreq;
  logic [13:0] up_waddr;
  logic [31:0] up_wdata;
  logic        up_wack;
  logic        up_werr;
  logic        up_rreq;
  logic [13:0] up_raddr;
  logic [31:0] up_rdata;
  logic        up_rack;
  logic        up_rerr;

  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;

  modport master (
    input  up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
    output up_wack, up_werr, up_rdata, up_rack, up_rerr,
    output m_axi_awvalid, m_axi_awaddr, m_axi_awprot,
    input  m_axi_awready,
    output m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
    input  m_axi_wready,
    input  m_axi_bvalid, m_axi_bresp,
    output m_axi_bready,
    output m_axi_arvalid, m_axi_araddr, m_axi_arprot,
    input  m_axi_arready,
    input  m_axi_rvalid, m_axi_rdata, m_axi_rresp,
    output m_axi_rready
  );

  modport slave (
    output up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
    input  up_wack, up_werr, up_rdata, up_rack, up_rerr,
    input  m_axi_awvalid, m_axi_awaddr, m_axi_awprot,
    output m_axi_awready,
    input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
    output m_axi_wready,
    output m_axi_bvalid, m_axi_bresp,
    input  m_axi_bready,
    input  m_axi_arvalid, m_axi_araddr, m_axi_arprot,
    output m_axi_arready,
    output m_axi_rvalid, m_axi_rdata, m_axi_rresp,
    input  m_axi_rready
  );
endinterface

// File: rtl/up_axi_master.sv
// Bridges single-cycle up_* register requests onto an AXI4-Lite master, one transaction at a time.
// A write and read requested together are served write first, then the latched read.
//
// state | meaning
// IDLE  | no transaction; accepts up_wreq/up_rreq or launches a pending read
// WADDR | driving AW and W until both have handshaken
// WRESP | bready high, waiting for B or the response timeout
// RADDR | driving AR until arready
// RDATA | rready high, waiting for R or the response timeout
module up_axi_master #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          TIMEOUT   = 1024
) (
  input logic              up_clk,
  input logic              up_rstn,
  up_axi_master_if.master  bus
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;

  localparam logic [15:0] TO_LOAD = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_rd_pend;
  logic [13:0] r_pend_addr;
  logic [15:0] r_cnt;
  logic        r_awvalid;
  logic [31:0] r_awaddr;
  logic        r_wvalid;
  logic [31:0] r_wdata;
  logic        r_bready;
  logic        r_arvalid;
  logic [31:0] r_araddr;
  logic        r_rready;
  logic        r_wack;
  logic        r_werr;
  logic        r_rack;
  logic        r_rerr;
  logic [31:0] r_rdata;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_done;
  logic w_w_done;

  function automatic logic [31:0] map_addr(input logic [13:0] a);
    return ADDR_BASE | {16'd0, a, 2'b00};
  endfunction

  assign w_aw_hs   = r_awvalid & bus.m_axi_awready;
  assign w_w_hs    = r_wvalid & bus.m_axi_wready;
  assign w_aw_done = ~r_awvalid | bus.m_axi_awready;
  assign w_w_done  = ~r_wvalid | bus.m_axi_wready;

  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      r_state     <= IDLE;
      r_rd_pend   <= 1'b0;
      r_pend_addr <= '0;
      r_cnt       <= '0;
      r_awvalid   <= 1'b0;
      r_awaddr    <= '0;
      r_wvalid    <= 1'b0;
      r_wdata     <= '0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_araddr    <= '0;
      r_rready    <= 1'b0;
      r_wack      <= 1'b0;
      r_werr      <= 1'b0;
      r_rack      <= 1'b0;
      r_rerr      <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_wack  <= 1'b0;
      r_werr  <= 1'b0;
      r_rack  <= 1'b0;
      r_rerr  <= 1'b0;
      r_rdata <= '0;
      case (r_state)
        IDLE: begin
          // A read held back behind a write launches in the cycle that shows up_wack.
          if (r_rd_pend) begin
            r_rd_pend <= 1'b0;
            r_arvalid <= 1'b1;
            r_araddr  <= map_addr(r_pend_addr);
            r_state   <= RADDR;
          end else if (bus.up_wreq) begin
            r_awvalid   <= 1'b1;
            r_wvalid    <= 1'b1;
            r_awaddr    <= map_addr(bus.up_waddr);
            r_wdata     <= bus.up_wdata;
            r_rd_pend   <= bus.up_rreq;
            r_pend_addr <= bus.up_raddr;
            r_state     <= WADDR;
          end else if (bus.up_rreq) begin
            r_arvalid <= 1'b1;
            r_araddr  <= map_addr(bus.up_raddr);
            r_state   <= RADDR;
          end
        end
        WADDR: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_cnt    <= TO_LOAD;
            r_state  <= WRESP;
          end
        end
        WRESP: begin
          if (bus.m_axi_bvalid && r_bready) begin
            r_bready <= 1'b0;
            r_wack   <= 1'b1;
            r_werr   <= (bus.m_axi_bresp != 2'b00);
            r_state  <= IDLE;
          end else if (r_cnt == 16'd0) begin
            r_bready <= 1'b0;
            r_wack   <= 1'b1;
            r_werr   <= 1'b1;
            r_state  <= IDLE;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        RADDR: begin
          if (bus.m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_cnt     <= TO_LOAD;
            r_state   <= RDATA;
          end
        end
        RDATA: begin
          if (bus.m_axi_rvalid && r_rready) begin
            r_rready <= 1'b0;
            r_rack   <= 1'b1;
            r_rerr   <= (bus.m_axi_rresp != 2'b00);
            r_rdata  <= bus.m_axi_rdata;
            r_state  <= IDLE;
          end else if (r_cnt == 16'd0) begin
            r_rready <= 1'b0;
            r_rack   <= 1'b1;
            r_rerr   <= 1'b1;
            r_rdata  <= 32'hDEAD_DEAD;
            r_state  <= IDLE;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.up_wack       = r_wack;
  assign bus.up_werr       = r_werr;
  assign bus.up_rack       = r_rack;
  assign bus.up_rerr       = r_rerr;
  assign bus.up_rdata      = r_rdata;
  assign bus.m_axi_awvalid = r_awvalid;
  assign bus.m_axi_awaddr  = r_awaddr;
  assign bus.m_axi_awprot  = 3'b000;
  assign bus.m_axi_wvalid  = r_wvalid;
  assign bus.m_axi_wdata   = r_wdata;
  assign bus.m_axi_wstrb   = 4'hF;
  assign bus.m_axi_bready  = r_bready;
  assign bus.m_axi_arvalid = r_arvalid;
  assign bus.m_axi_araddr  = r_araddr;
  assign bus.m_axi_arprot  = 3'b000;
  assign bus.m_axi_rready  = r_rready;

endmodule
